// File: rtl/transposed_convolution_layer.sv
// Stride-1 single-channel 2D transposed convolution: each pixel scatters pixel*kernel into an OUT_W x OUT_H accumulator map.
// Latency: K*K scatter cycles per accepted pixel; the map drains in raster order after the last pixel of a frame.
// Backpressure: in_ready low while scattering or draining; the drain holds out_data/out_last while out_ready is low.
// Optional macro TRANSPOSED_CONV_RELU_EN clamps negative drained values to zero (stored accumulators unaffected).
module transposed_convolution_layer #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IN_W        = 4,
    parameter int IN_H        = 4,
    parameter int ACC_WIDTH   = 20
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       k_we,
    input  logic [$clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0] k_addr,
    input  logic [DATA_WIDTH-1:0]                      k_data,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [DATA_WIDTH-1:0]                      in_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [ACC_WIDTH-1:0]                       out_data,
    output logic                                       out_last,
    output logic                                       busy,
    output logic                                       frame_done
);
    localparam int K     = KERNEL_SIZE;
    localparam int KK    = K * K;
    localparam int OUT_W = IN_W + K - 1;
    localparam int OUT_H = IN_H + K - 1;
    localparam int NOUT  = OUT_W * OUT_H;
    localparam int KAW   = $clog2(KK);
    localparam int IDXW  = $clog2(NOUT);
    localparam int TW    = $clog2(K + 1);
    localparam int RW    = $clog2(IN_H + 1);
    localparam int CW    = $clog2(IN_W + 1);
    localparam int PW    = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_SCATTER, S_DRAIN} state_t;

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  w_q [KK];
    logic signed [DATA_WIDTH-1:0]  w_d [KK];
    logic signed [DATA_WIDTH-1:0]  wk_q [KK];
    logic signed [DATA_WIDTH-1:0]  wk_d [KK];
    logic signed [ACC_WIDTH-1:0]   acc_q [NOUT];
    logic signed [ACC_WIDTH-1:0]   acc_d [NOUT];
    logic signed [DATA_WIDTH-1:0]  pix_q, pix_d;
    logic [RW-1:0]                 px_row_q, px_row_d, in_row_q, in_row_d;
    logic [CW-1:0]                 px_col_q, px_col_d, in_col_q, in_col_d;
    logic                          last_px_q, last_px_d;
    logic [TW-1:0]                 kr_q, kr_d, kc_q, kc_d;
    logic [IDXW-1:0]               idx_q, idx_d;
    logic                          busy_q, busy_d;
    logic                          frame_done_q, frame_done_d;

    logic [KAW-1:0]                tap;
    logic [IDXW-1:0]               scat_addr;
    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]          drain_val;

    // Scatter datapath: current tap's target cell and the sign-extended product.
    always_comb begin
        tap       = KAW'(32'(kr_q) * K + 32'(kc_q));
        scat_addr = IDXW'((32'(px_row_q) + 32'(kr_q)) * OUT_W + 32'(px_col_q) + 32'(kc_q));
        prod      = pix_q * wk_q[tap];
        prod_ext  = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
`ifdef TRANSPOSED_CONV_RELU_EN
        drain_val = acc_q[idx_q][ACC_WIDTH-1] ? '0 : acc_q[idx_q];
`else
        drain_val = acc_q[idx_q];
`endif
    end

    // Next-state logic for the IDLE / SCATTER / DRAIN controller and all datapath state.
    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        wk_d         = wk_q;
        acc_d        = acc_q;
        pix_d        = pix_q;
        px_row_d     = px_row_q;
        px_col_d     = px_col_q;
        in_row_d     = in_row_q;
        in_col_d     = in_col_q;
        last_px_d    = last_px_q;
        kr_d         = kr_q;
        kc_d         = kc_q;
        idx_d        = idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Weights only change between frames; a frame works from a snapshot taken at its first pixel,
                // so a write coinciding with that pixel lands in w_q but not in the snapshot.
                if (k_we && !busy_q && (32'(k_addr) < KK)) begin
                    w_d[k_addr] = k_data;
                end
                if (in_valid) begin
                    pix_d     = in_data;
                    px_row_d  = in_row_q;
                    px_col_d  = in_col_q;
                    last_px_d = (in_row_q == RW'(IN_H - 1)) && (in_col_q == CW'(IN_W - 1));
                    if (in_col_q == CW'(IN_W - 1)) begin
                        in_col_d = '0;
                        in_row_d = in_row_q + 1'b1;
                    end else begin
                        in_col_d = in_col_q + 1'b1;
                    end
                    if (!busy_q) begin
                        wk_d = w_q;
                    end
                    busy_d  = 1'b1;
                    kr_d    = '0;
                    kc_d    = '0;
                    state_d = S_SCATTER;
                end
            end
            S_SCATTER: begin
                acc_d[scat_addr] = acc_q[scat_addr] + prod_ext;
                if (kc_q == TW'(K - 1)) begin
                    kc_d = '0;
                    if (kr_q == TW'(K - 1)) begin
                        kr_d    = '0;
                        idx_d   = '0;
                        state_d = last_px_q ? S_DRAIN : S_IDLE;
                    end else begin
                        kr_d = kr_q + 1'b1;
                    end
                end else begin
                    kc_d = kc_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Clearing on read leaves the map all-zero for the next frame.
                if (out_ready) begin
                    acc_d[idx_q] = '0;
                    if (idx_q == IDXW'(NOUT - 1)) begin
                        idx_d        = '0;
                        in_row_d     = '0;
                        in_col_d     = '0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset clearing weights, accumulators and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pix_q        <= '0;
            px_row_q     <= '0;
            px_col_q     <= '0;
            in_row_q     <= '0;
            in_col_q     <= '0;
            last_px_q    <= 1'b0;
            kr_q         <= '0;
            kc_q         <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < KK; i++) begin
                w_q[i]  <= '0;
                wk_q[i] <= '0;
            end
            for (int i = 0; i < NOUT; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            px_row_q     <= px_row_d;
            px_col_q     <= px_col_d;
            in_row_q     <= in_row_d;
            in_col_q     <= in_col_d;
            last_px_q    <= last_px_d;
            kr_q         <= kr_d;
            kc_q         <= kc_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            w_q          <= w_d;
            wk_q         <= wk_d;
            acc_q        <= acc_d;
        end
    end

    // Port outputs decoded from the current state.
    always_comb begin
        in_ready   = (state_q == S_IDLE);
        out_valid  = (state_q == S_DRAIN);
        out_data   = out_valid ? drain_val : '0;
        out_last   = out_valid && (idx_q == IDXW'(NOUT - 1));
        busy       = busy_q;
        frame_done = frame_done_q;
    end
endmodule

// File: tb/tb_transposed_convolution_layer.sv
// Randomized bench for transposed_convolution_layer against a gather-form reference model.
// Checks reset state, directed kernels, backpressure hold, ignored busy writes and mid-frame reset.
// Downstream readiness is randomized; waits are bounded.
module tb_transposed_convolution_layer;
    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int AW   = 20;
    localparam int KK   = K * K;
    localparam int OW   = IW + K - 1;
    localparam int OH   = IH + K - 1;
    localparam int NOUT = OW * OH;
    localparam int NIN  = IW * IH;
    localparam int KAW  = $clog2(KK);

    logic           clk = 1'b0;
    logic           rst;
    logic           k_we;
    logic [KAW-1:0] k_addr;
    logic [DW-1:0]  k_data;
    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_data;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  out_data;
    logic           out_last;
    logic           busy;
    logic           frame_done;

    transposed_convolution_layer #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IN_W(IW), .IN_H(IH), .ACC_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int             total = 0;
    int             bad   = 0;
    int             w_m   [KK];
    int             pix_m [NIN];
    logic [AW-1:0]  exp_m [NOUT];
    logic [AW-1:0]  got_m [NOUT];
    logic [KAW-1:0] kwf_addr;
    logic [DW-1:0]  kwf_val;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Gather form: out(y,x) = sum over taps of in(y-kr, x-kc) * w(kr,kc), wrapped to AW bits.
    function automatic void compute_expected();
        for (int y = 0; y < OH; y++) begin
            for (int x = 0; x < OW; x++) begin
                longint        s;
                logic [AW-1:0] v;
                s = 0;
                for (int kr = 0; kr < K; kr++) begin
                    for (int kc = 0; kc < K; kc++) begin
                        int iy, ix;
                        iy = y - kr;
                        ix = x - kc;
                        if (iy >= 0 && iy < IH && ix >= 0 && ix < IW)
                            s += longint'(pix_m[iy * IW + ix]) * longint'(w_m[kr * K + kc]);
                    end
                end
                v = s[AW-1:0];
`ifdef TRANSPOSED_CONV_RELU_EN
                if (v[AW-1]) v = '0;
`endif
                exp_m[y * OW + x] = v;
            end
        end
    endfunction

    task automatic load_weights();
        for (int t = 0; t < KK; t++) begin
            int tmp;
            tmp = w_m[t];
            @(negedge clk);
            k_we   = 1'b1;
            k_addr = KAW'(t);
            k_data = tmp[DW-1:0];
        end
        @(negedge clk);
        k_we = 1'b0;
    endtask

    task automatic send_pixels(input int n, input int gap_pct, input bit kw_first, input bit kw_busy);
        for (int i = 0; i < n; i++) begin
            int g;
            int tmp;
            tmp = pix_m[i];
            g = 0;
            @(negedge clk);
            while (($urandom_range(99) < gap_pct) && g < 8) begin
                @(negedge clk);
                g++;
            end
            g = 0;
            while (!in_ready && g < 100) begin
                @(negedge clk);
                g++;
            end
            if (!in_ready) begin
                check_eq("in_ready_timeout", 0, 1);
                in_valid = 1'b0;
                k_we     = 1'b0;
                return;
            end
            in_valid = 1'b1;
            in_data  = tmp[DW-1:0];
            if (i == 0 && kw_first) begin
                k_we   = 1'b1;
                k_addr = kwf_addr;
                k_data = kwf_val;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            k_we     = 1'b0;
            if (i == 0) begin
                check_eq("busy_after_first", busy, 1);
                check_eq("in_ready_scatter", in_ready, 0);
            end
            if (kw_busy && i < n - 1) begin
                k_we   = 1'b1;
                k_addr = KAW'(4);
                k_data = 8'd7;
            end
        end
    endtask

    task automatic collect(input int bp_pct, input int bp_idx);
        int i, guard, held;
        i = 0; guard = 0; held = 0;
        while (i < NOUT && guard < 3000) begin
            @(negedge clk);
            guard++;
            if (out_valid && i == bp_idx && held < 5) begin
                out_ready = 1'b0;
                check_eq("bp_hold_data", out_data, exp_m[i]);
                held++;
            end else begin
                out_ready = ($urandom_range(99) >= bp_pct);
            end
            if (out_valid && out_ready) begin
                got_m[i] = out_data;
                check_eq("out_data", out_data, exp_m[i]);
                check_eq("out_last", out_last, (i == NOUT - 1));
                i++;
            end
        end
        if (i < NOUT) check_eq("drain_timeout", i, NOUT);
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("frame_done_pulse", frame_done, 1);
        check_eq("busy_cleared", busy, 0);
        check_eq("out_valid_after", out_valid, 0);
        @(negedge clk);
        check_eq("frame_done_low", frame_done, 0);
        check_eq("in_ready_idle", in_ready, 1);
    endtask

    task automatic run_frame(input int gap_pct, input int bp_pct, input int bp_idx,
                             input bit kw_first, input bit kw_busy);
        compute_expected();
        send_pixels(NIN, gap_pct, kw_first, kw_busy);
        if (kw_first) begin
            logic [DW-1:0] b;
            b = kwf_val;
            w_m[kwf_addr] = int'($signed(b));
        end
        collect(bp_pct, bp_idx);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; k_we = 1'b0; k_addr = '0; k_data = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_frame_done", frame_done, 0);

        // All-ones kernel and image.
        for (int t = 0; t < KK; t++) w_m[t] = 1;
        for (int i = 0; i < NIN; i++) pix_m[i] = 1;
        load_weights();
        run_frame(0, 0, -1, 0, 0);
        check_eq("ones_r0c0", got_m[0], 1);
        check_eq("ones_r0c2", got_m[2], 3);
        check_eq("ones_r2c2", got_m[2 * OW + 2], 9);
        check_eq("ones_r2c5", got_m[2 * OW + 5], 3);

        // Identity kernel, ramp image, backpressure held at element 10.
        for (int t = 0; t < KK; t++) w_m[t] = (t == 4) ? 1 : 0;
        for (int i = 0; i < NIN; i++) pix_m[i] = i;
        load_weights();
        run_frame(20, 0, 10, 0, 0);
        check_eq("ident_border", got_m[0], 0);
        check_eq("ident_r1c2", got_m[OW + 2], 1);
        check_eq("ident_r4c4", got_m[4 * OW + 4], 15);

        // Kernel writes while busy must be ignored.
        run_frame(10, 25, -1, 0, 1);
        check_eq("busywr_r2c1", got_m[2 * OW + 1], 4);

        // Single negative tap product in the corner.
        for (int t = 0; t < KK; t++) w_m[t] = (t == 0) ? 3 : 0;
        for (int i = 0; i < NIN; i++) pix_m[i] = (i == 0) ? -2 : 0;
        load_weights();
        run_frame(0, 30, -1, 0, 0);
`ifdef TRANSPOSED_CONV_RELU_EN
        check_eq("neg_corner", got_m[0], 0);
`else
        check_eq("neg_corner", got_m[0], 20'hFFFFA);
`endif

        // Random kernels and images; first frame also writes a weight alongside its first pixel.
        for (int f = 0; f < 4; f++) begin
            if (f != 1) begin
                for (int t = 0; t < KK; t++) begin
                    byte sb;
                    sb = byte'($urandom);
                    w_m[t] = sb;
                end
                load_weights();
            end
            for (int i = 0; i < NIN; i++) begin
                byte sb;
                sb = byte'($urandom);
                pix_m[i] = sb;
            end
            kwf_addr = KAW'($urandom_range(KK - 1));
            kwf_val  = DW'($urandom);
            run_frame(30, 30, -1, (f == 0), 0);
        end

        // Reset during the scatter of pixel 5 of an all-ones frame.
        for (int t = 0; t < KK; t++) w_m[t] = 1;
        for (int i = 0; i < NIN; i++) pix_m[i] = 1;
        load_weights();
        send_pixels(6, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        // Weights are cleared by reset and no accumulator residue may remain.
        for (int t = 0; t < KK; t++) w_m[t] = 0;
        for (int i = 0; i < NIN; i++) pix_m[i] = int'($urandom_range(255)) - 128;
        run_frame(10, 20, -1, 0, 0);
        for (int t = 0; t < KK; t++) w_m[t] = 1;
        for (int i = 0; i < NIN; i++) pix_m[i] = 1;
        load_weights();
        run_frame(0, 0, -1, 0, 0);
        check_eq("post_rst_r0c1", got_m[1], 2);
        check_eq("post_rst_r2c3", got_m[2 * OW + 3], 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/transposed_convolution_layer.md
Name: transposed_convolution_layer

Overview:
Streaming single-channel 2D transposed convolution (deconvolution), stride 1. It is the upsampling counterpart of the forward convolution layer in the CNN datapath. Each input pixel is scattered as pixel×kernel into an on-chip accumulator map of size (IN_W+K-1)×(IN_H+K-1). The finished map is then streamed out in raster order over a valid/ready interface.

Parameters:
DATA_WIDTH, 8, width of input pixels and kernel weights (signed two's complement)
KERNEL_SIZE, 3, kernel edge K; the kernel holds K*K weights
IN_W, 4, input image width in pixels
IN_H, 4, input image height in pixels
ACC_WIDTH, 20, accumulator and output width (signed); must be >= 2*DATA_WIDTH + clog2(K*K)

Ports:
clk  input  1  clock; all logic is rising-edge
rst  input  1  synchronous, active-high reset
k_we  input  1  kernel weight write strobe
k_addr  input  clog2(K*K)  weight index, kr*K+kc
k_data  input  DATA_WIDTH  weight value
in_valid  input  1  input pixel valid
in_ready  output  1  block can accept a pixel
in_data  input  DATA_WIDTH  input pixel, raster order, row 0 col 0 first
out_valid  output  1  output accumulator valid
out_ready  input  1  downstream accepts output
out_data  output  ACC_WIDTH  output value, raster order over OUT_W×OUT_H
out_last  output  1  high with the final output element of a frame
busy  output  1  a frame is in progress (any pixel accepted, drain not finished)
frame_done  output  1  one-cycle pulse after the last output handshake

Behaviour:
- Derived sizes: OUT_W = IN_W+K-1, OUT_H = IN_H+K-1, NOUT = OUT_W*OUT_H.
- Reset, synchronous: state=S_IDLE; in/out counters=0; every accumulator=0; every kernel weight=0. Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, frame_done=0.
- State S_IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch the pixel and its (row,col) from the input counter, increment the input counter, set busy, go to S_SCATTER.
- State S_SCATTER:
  - in_ready=0. Runs exactly K*K cycles; tap counter t=0..K*K-1, kr=t/K, kc=t%K.
  - Each cycle: acc[(row+kr)*OUT_W + col+kc] += sext(pix*w[t]).
  - The product is a full 2*DATA_WIDTH signed value, sign-extended to ACC_WIDTH. Accumulation wraps modulo 2^ACC_WIDTH.
  - After tap K*K-1: if the pixel was input number IN_W*IN_H-1, go to S_DRAIN with output index=0; otherwise go to S_IDLE.
  - Accepted throughput: one pixel per K*K+1 cycles at most.
- State S_DRAIN:
  - out_valid=1 and out_data=acc[idx], shown combinationally from the buffer (with the optional transform below).
  - out_last=(idx==NOUT-1).
  - out_data and out_last hold stable while out_valid&&!out_ready.
  - On a handshake: acc[idx] is cleared to 0 and idx increments.
  - On the handshake with out_last: go to S_IDLE, clear busy, reset counters, and pulse frame_done for the next cycle.
  - The buffer is therefore all-zero at the start of every frame.
- Kernel writes:
  - Accepted only when busy=0 and state=S_IDLE; otherwise ignored.
  - Simultaneous k_we and an accepted first pixel: the write takes effect and the pixel uses the old weights.
- Weights persist across frames and are cleared only by reset.
- in_valid while in_ready=0: the block does not accept the pixel; the upstream must hold it.
- Reset mid-operation (any state) aborts the frame, zeroes all accumulators and weights, and drops out_valid the next cycle.

Optional Feature:
Macro TRANSPOSED_CONV_RELU_EN.
- Defined: out_data = (acc[idx] < 0) ? 0 : acc[idx]. ReLU is applied at drain only; the stored accumulators are unaffected.
- Undefined: out_data = acc[idx], raw signed value.
- Handshake and timing are identical in both builds.

Test Plan:
- All weights=1 and all 16 pixels=1 (defaults) -> 36 outputs. Row 0 = 1,2,3,3,2,1. Row 2 = 3,6,9,9,6,3. out_last on element 35. frame_done one cycle later.
- Identity kernel (w[4]=1, others 0), pixels 0..15 -> output(r+1,c+1)=pixel(r,c) and all border entries 0.
- w[0]=3, single frame whose pixel(0,0)=-2 and the rest 0 -> out_data[0]=-6 (0xFFFFA) without RELU_EN, 0 with RELU_EN. All other outputs 0.
- Backpressure: hold out_ready=0 for 5 cycles at idx=10 -> out_data constant, idx does not advance. Release -> idx 11 on the next cycle. No element lost or duplicated.
- Kernel write (k_addr=4, k_data=7) while busy=1 is ignored. Rerun of the identity frame gives unchanged output.
- Assert rst during S_SCATTER of pixel 5, then run the all-ones frame -> output matches the first scenario exactly, with no residue.
